// File: rtl/fsm_eg_driver.sv
// fsm_eg_driver
//   Test-sequence driver for a small target FSM. On request it pulses the
//   target's reset, drives an 8-step {a,b} stimulus pattern, compares the
//   returned {y0,yl} against the known-good response, and reports the
//   mismatch count and the step index of the first mismatch.
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   synchronous, active-high reset
//   start      in   run request, honoured only in IDLE
//   loop       in   sampled in DONE; 1 restarts the sequence immediately
//   y0         in   Mealy output of the target
//   yl         in   Moore output of the target
//   a, b       out  stimulus bits to the target (registered)
//   dut_reset  out  reset pulse to the target (registered)
//   busy       out  high in RST, RUN and DONE
//   done       out  one-cycle pulse at the end of each sequence
//   err_cnt    out  mismatch count for the current sequence, saturates at 15
//   first_err  out  step index of the first mismatch, valid when err_cnt != 0

module fsm_eg_driver (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       loop,
    input  logic       y0,
    input  logic       yl,
    output logic       a,
    output logic       b,
    output logic       dut_reset,
    output logic       busy,
    output logic       done,
    output logic [3:0] err_cnt,
    output logic [2:0] first_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_step;
    logic [2:0] w_step_nxt;
    logic [1:0] w_ab_nxt;
    logic       w_mismatch;

    logic       r_a;
    logic       r_b;
    logic       r_dut_reset;
    logic [3:0] r_err_cnt;
    logic [2:0] r_first_err;

    // Stimulus pattern {a,b} for each step.
    function automatic logic [1:0] stim_ab(input logic [2:0] s);
        logic [1:0] v;
        case (s)
            3'd0:    v = 2'b00;
            3'd1:    v = 2'b10;
            3'd2:    v = 2'b01;
            3'd3:    v = 2'b10;
            3'd4:    v = 2'b11;
            3'd5:    v = 2'b00;
            3'd6:    v = 2'b11;
            default: v = 2'b11;
        endcase
        return v;
    endfunction

    // Known-good {y0,yl} response of the target, starting from S0.
    function automatic logic [1:0] exp_y(input logic [2:0] s);
        logic [1:0] v;
        case (s)
            3'd0:    v = 2'b01;
            3'd1:    v = 2'b01;
            3'd2:    v = 2'b01;
            3'd3:    v = 2'b01;
            3'd4:    v = 2'b11;
            3'd5:    v = 2'b00;
            3'd6:    v = 2'b11;
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_ab_nxt    = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RST;
                end
            end
            RST: begin
                w_state_nxt = RUN;
                w_step_nxt  = '0;
            end
            RUN: begin
                if (r_step == 3'd7) begin
                    w_state_nxt = DONE;
                    w_step_nxt  = '0;
                end else begin
                    w_step_nxt = r_step + 3'd1;
                end
            end
            DONE: begin
                w_state_nxt = loop ? RST : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_step_nxt  = '0;
            end
        endcase
        // a/b/dut_reset are flops, so they are loaded from the state and
        // step the controller is about to enter.
        if (w_state_nxt == RUN) begin
            w_ab_nxt = stim_ab(w_step_nxt);
        end
    end

    // The response seen during a RUN cycle is judged at that cycle's closing edge.
    assign w_mismatch = (r_state == RUN) && ({y0, yl} != exp_y(r_step));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_step      <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_dut_reset <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_a         <= w_ab_nxt[1];
            r_b         <= w_ab_nxt[0];
            r_dut_reset <= (w_state_nxt == RST);
            if (w_state_nxt == RST) begin
                r_err_cnt   <= '0;
                r_first_err <= '0;
            end else if (w_mismatch) begin
                // Counter is cleared at sequence start, so zero marks the first miss.
                if (r_err_cnt == 4'd0) begin
                    r_first_err <= r_step;
                end
                if (r_err_cnt != 4'd15) begin
                    r_err_cnt <= r_err_cnt + 4'd1;
                end
            end
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign dut_reset = r_dut_reset;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign err_cnt   = r_err_cnt;
    assign first_err = r_first_err;

endmodule

// File: tb/tb_fsm_eg_driver.sv
// tb_fsm_eg_driver
//   Directed bench for fsm_eg_driver. The target FSM is replaced by per-step
//   {y0,yl} response vectors (bit s of each mask is the value at step s).
//
// Ports: none (top-level bench).

module tb_fsm_eg_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       loop;
    logic       y0;
    logic       yl;
    logic       a;
    logic       b;
    logic       dut_reset;
    logic       busy;
    logic       done;
    logic [3:0] err_cnt;
    logic [2:0] first_err;

    int unsigned n_pass = 0;
    int unsigned n_fail = 0;
    int unsigned n_tot  = 0;
    int unsigned done_cnt = 0;

    logic [1:0] ab_tab [8] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b11};

    // Correct target responses: y0 high at steps 4,6; yl high at 0-4,6.
    localparam logic [7:0] Y0_OK  = 8'h50;
    localparam logic [7:0] YL_OK  = 8'h5F;
    localparam logic [7:0] Y0_INV = 8'hAF;
    localparam logic [7:0] YL_INV = 8'hA0;

    fsm_eg_driver u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .loop      (loop),
        .y0        (y0),
        .yl        (yl),
        .a         (a),
        .b         (b),
        .dut_reset (dut_reset),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .first_err (first_err)
    );

    always #5 clk = ~clk;

    // done is stable mid-cycle; count DONE cycles there.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered during the RST cycle; returns during the DONE cycle.
    task automatic run_body(input logic [7:0] y0v, input logic [7:0] ylv,
                            input logic [3:0] exp_err, input logic [2:0] exp_first,
                            input bit pulse_start);
        chk("rst_busy", busy, 1);
        chk("rst_dut_reset", dut_reset, 1);
        chk("rst_ab", {a, b}, 2'b00);
        chk("rst_err_clr", err_cnt, 0);
        chk("rst_first_clr", first_err, 0);
        for (int s = 0; s < 8; s++) begin
            tick;
            chk($sformatf("run_ab_step%0d", s), {a, b}, ab_tab[s]);
            chk($sformatf("run_busy_step%0d", s), {busy, done, dut_reset}, 3'b100);
            y0 = y0v[s];
            yl = ylv[s];
            if (pulse_start) start = (s == 3);
        end
        tick;
        y0 = 1'b1;
        yl = 1'b1;
        chk("done_flags", {busy, done, dut_reset}, 3'b110);
        chk("done_ab", {a, b}, 2'b00);
        chk("done_err_cnt", err_cnt, exp_err);
        chk("done_first_err", first_err, exp_first);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        loop  = 1'b0;
        y0    = 1'b0;
        yl    = 1'b0;

        // Reset wins over start.
        tick;
        tick;
        chk("reset_outs", {a, b, dut_reset, busy, done}, 5'b00000);
        chk("reset_err", {err_cnt, first_err}, 7'd0);
        reset = 1'b0;
        start = 1'b0;
        tick;
        chk("idle_after_reset", {busy, done, dut_reset}, 3'b000);

        // Correct target.
        start = 1'b1;
        tick;
        start = 1'b0;
        run_body(Y0_OK, YL_OK, 4'd0, 3'd0, 1'b0);
        tick;
        chk("idle1_flags", {busy, done, a, b}, 4'b0000);
        chk("done_cnt1", done_cnt, 1);

        // yl stuck at 1: misses at steps 5 and 7.
        start = 1'b1;
        tick;
        start = 1'b0;
        run_body(Y0_OK, 8'hFF, 4'd2, 3'd5, 1'b0);
        tick;
        tick;
        chk("idle_hold_err", err_cnt, 2);
        chk("idle_hold_first", first_err, 5);

        // Both outputs inverted, three looped runs.
        loop  = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int r = 0; r < 3; r++) begin
            run_body(Y0_INV, YL_INV, 4'd8, 3'd0, 1'b0);
            if (r == 2) loop = 1'b0;
            tick;
        end
        chk("idle_after_loop", busy, 0);
        chk("done_cnt_loop", done_cnt, 5);

        // Reset in the middle of RUN (step 3) with errors accumulated.
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick;
            y0 = Y0_INV[s];
            yl = YL_INV[s];
        end
        tick;
        chk("step3_ab", {a, b}, 2'b10);
        chk("step3_err", err_cnt, 3);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("abort_outs", {a, b, dut_reset, busy, done}, 5'b00000);
        chk("abort_err", {err_cnt, first_err}, 7'd0);
        tick;
        chk("abort_idle", {busy, done}, 2'b00);
        chk("abort_no_done", done_cnt, 5);

        // start pulsed during RUN is ignored.
        start = 1'b1;
        tick;
        start = 1'b0;
        run_body(Y0_OK, YL_OK, 4'd0, 3'd0, 1'b1);
        tick;
        tick;
        chk("ignored_start_idle", busy, 0);
        chk("done_cnt_pulse", done_cnt, 6);
        start = 1'b1;
        tick;
        start = 1'b0;
        run_body(Y0_OK, YL_OK, 4'd0, 3'd0, 1'b0);
        tick;
        chk("done_cnt_restart", done_cnt, 7);

        // start held high: one run per return to IDLE.
        start = 1'b1;
        tick;
        run_body(Y0_OK, YL_OK, 4'd0, 3'd0, 1'b0);
        tick;
        chk("held_idle", {busy, done}, 2'b00);
        tick;
        chk("held_rerun", {busy, dut_reset}, 2'b11);
        start = 1'b0;
        run_body(Y0_OK, YL_OK, 4'd0, 3'd0, 1'b0);
        tick;
        chk("held_final_idle", busy, 0);
        chk("done_cnt_held", done_cnt, 9);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fsm_eg_driver.md
FSM_EG_DRIVER -- requirements
Module: fsm_eg_driver

Interface
REQ-001 The module SHALL have exactly these ports, in this order:
- clk  input  1  rising-edge system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to run the test sequence; honoured only in IDLE.
- loop  input  1  sampled in DONE; 1 = restart the sequence immediately.
- y0  input  1  Mealy output returned by the target FSM.
- yl  input  1  Moore output returned by the target FSM.
- a  output  1  stimulus bit a to the target FSM, driven from a flop.
- b  output  1  stimulus bit b to the target FSM, driven from a flop.
- dut_reset  output  1  reset pulse to the target FSM, driven from a flop.
- busy  output  1  high in RST, RUN and DONE.
- done  output  1  one-cycle pulse at the end of each sequence.
- err_cnt  output  4  mismatch count for the current sequence; saturates at 15.
- first_err  output  3  step index of the first mismatch; valid when err_cnt != 0.

Function
REQ-002 The controller SHALL have four states: IDLE, RST, RUN and DONE.
- IDLE -> RST when start=1.
- RST -> RUN unconditionally.
- RUN stays in RUN for 8 cycles, step 0..7, then -> DONE.
- DONE -> RST if loop=1, otherwise -> IDLE.
REQ-003 In RST, dut_reset SHALL be 1 for exactly one cycle, with a=b=0; dut_reset SHALL be 0 in every other state.
REQ-004 In RUN, {a,b} SHALL equal the fixed table at the current step:
- step 0..7 = 00, 10, 01, 10, 11, 00, 11, 11.
REQ-005 In IDLE and DONE, a=b=0.
REQ-006 In RUN, the expected {y0,yl} SHALL be:
- step 0..7 = 01, 01, 01, 01, 11, 00, 11, 00.
- This table is the target's S0/S1/S2 response path starting from S0.
REQ-007 At each RUN clock edge, if {y0,yl} differs from the expected value, err_cnt SHALL increment by 1, saturating at 15 with no wrap.
REQ-008 At the first mismatch of a sequence, first_err SHALL latch the step index; later mismatches SHALL leave it unchanged.
REQ-009 On entry to RST (from IDLE or by loop), err_cnt and first_err SHALL clear to 0.
REQ-010 In DONE, done=1 for exactly one cycle; err_cnt SHALL already include the step-7 comparison.
REQ-011 Timing from start sampled high at edge t:
- RST during cycle t+1.
- RUN during cycles t+2 to t+9.
- DONE during cycle t+10.
- IDLE from cycle t+11 (loop=0).
REQ-012 start SHALL be ignored while busy=1.
REQ-013 start=1 held continuously SHALL cause exactly one run per return to IDLE.
REQ-014 y0 and yl SHALL be ignored outside RUN.
REQ-015 err_cnt and first_err SHALL hold their values in IDLE until the next RST.
REQ-016 The step counter SHALL be 3 bits; step 7 -> DONE with no further RUN cycle.

Reset
REQ-017 When reset=1 at a clk edge, the module SHALL enter IDLE with all outputs 0 (a, b, dut_reset, busy, done, err_cnt, first_err) and step=0.
REQ-018 Reset SHALL override every other input, including start in the same cycle and reset in the middle of RUN.
REQ-019 After reset is released, the next cycle SHALL be IDLE; no done pulse SHALL be produced for an aborted sequence.

Verification
REQ-020 Connected to a correct target FSM, start pulse -> a/b follow the REQ-004 table for 8 cycles, done at t+10, err_cnt=0.
REQ-021 yl forced to 1 -> mismatches at steps 5 and 7 -> at done, err_cnt=2 and first_err=5.
REQ-022 y0 and yl both inverted -> 8 mismatches -> err_cnt=8, first_err=0; three back-to-back runs with loop=1 -> err_cnt still 8 at each done (cleared per run, never accumulates to saturation).
REQ-023 loop=1 held -> DONE goes straight to RST, with a dut_reset pulse every 10 cycles and busy never dropping.
REQ-024 reset asserted at RUN step 3 -> next cycle: IDLE, a=b=0, err_cnt=0, busy=0, no done pulse.
REQ-025 start pulsed during RUN -> no effect; exactly one done pulse; then start in IDLE -> new run begins normally.
